// File: rtl/dff_set_clr.sv
// Positive-edge D register chain (STAGES deep) with synchronous active-low clear and set.
// Define DFF_QN_EN to add the complemented output Dout_n.
module dff_set_clr #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             set,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout
`ifdef DFF_QN_EN
  ,
  output logic [WIDTH-1:0] Dout_n
`endif
);

  generate
    if (STAGES < 1 || WIDTH < 1) begin : g_bad_cfg
      $error("dff_set_clr: WIDTH and STAGES must both be >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  // clr outranks set; either one overwrites every stage, flushing in-flight data
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stage_d[k] = stage_q[k];
    end
    if (!clr) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_d[k] = '0;
      end
    end else if (!set) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_d[k] = '1;
      end
    end else begin
      stage_d[0] = Din;
      for (int k = 1; k < STAGES; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      stage_q[k] <= stage_d[k];
    end
  end

  assign Dout = stage_q[STAGES-1];

`ifdef DFF_QN_EN
  assign Dout_n = ~stage_q[STAGES-1];
`endif

endmodule

// File: tb/tb_dff_set_clr.sv
// Randomized scoreboard bench for dff_set_clr (WIDTH=4, STAGES=3); expected Dout is
// derived from the input history over the last STAGES edges.
module tb_dff_set_clr;

  localparam int W = 4;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         clr;
  logic         set;
  logic [W-1:0] Din;
  logic [W-1:0] Dout;
`ifdef DFF_QN_EN
  logic [W-1:0] Dout_n;
`endif

  int errors = 0;
  int checks = 0;

  logic         h_clr [$];
  logic         h_set [$];
  logic [W-1:0] h_din [$];
  logic [W-1:0] exp_q [$];

  logic [W-1:0] last_exp;
  bit           have_exp = 0;
  bit           stim_done = 0;

  dff_set_clr #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .clr   (clr),
    .set   (set),
    .Din   (Din),
    .Dout  (Dout)
`ifdef DFF_QN_EN
    ,
    .Dout_n(Dout_n)
`endif
  );

  always #5 clk = ~clk;

  // Output after the newest edge: the latest clr/set within the last S edges wins,
  // otherwise the Din sampled S-1 edges earlier.
  function automatic logic [W-1:0] model_out();
    int n = h_din.size();
    for (int i = n - 1; i >= n - S && i >= 0; i--) begin
      if (h_clr[i] == 1'b0) return '0;
      if (h_set[i] == 1'b0) return '1;
    end
    if (n < S) return 'x;
    return h_din[n - S];
  endfunction

  task automatic drive(input logic c, input logic s, input logic [W-1:0] d);
    @(negedge clk);
    clr = c;
    set = s;
    Din = d;
    h_clr.push_back(c);
    h_set.push_back(s);
    h_din.push_back(d);
    exp_q.push_back(model_out());
  endtask

  // Monitor: compare after every rising edge, and check stability mid-cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        last_exp = exp_q.pop_front();
        have_exp = 1;
        checks++;
        if (Dout !== last_exp) begin
          errors++;
          $display("FAIL edge_dout t=%0t got=%h exp=%h", $time, Dout, last_exp);
        end
`ifdef DFF_QN_EN
        checks++;
        if (Dout_n !== ~last_exp) begin
          errors++;
          $display("FAIL edge_dout_n t=%0t got=%h exp=%h", $time, Dout_n, ~last_exp);
        end
`endif
      end
      @(negedge clk);
      #1;
      if (have_exp && !stim_done) begin
        checks++;
        if (Dout !== last_exp) begin
          errors++;
          $display("FAIL mid_cycle_hold t=%0t got=%h exp=%h", $time, Dout, last_exp);
        end
      end
    end
  end

  initial begin
    clr = 1'b0;
    set = 1'b1;
    Din = '1;
    // Directed: clear, clr-over-set, set hold, then a 1/0/1 walk through the pipe
    drive(1'b0, 1'b1, 4'hF);
    drive(1'b0, 1'b0, 4'hF);
    drive(1'b1, 1'b0, 4'h0);
    drive(1'b1, 1'b0, 4'h0);
    drive(1'b1, 1'b0, 4'h0);
    drive(1'b1, 1'b1, 4'h1);
    drive(1'b1, 1'b1, 4'h0);
    drive(1'b1, 1'b1, 4'h1);
    drive(1'b1, 1'b1, 4'hA);
    drive(1'b1, 1'b1, 4'h5);
    drive(1'b0, 1'b1, 4'h3);
    drive(1'b1, 1'b1, 4'h6);
    drive(1'b1, 1'b1, 4'h9);
    drive(1'b1, 1'b1, 4'hC);
    // Random traffic with occasional clear/set pulses
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 11) != 0),
            W'($urandom_range(0, (1 << W) - 1)));
    end
    @(negedge clk);
    stim_done = 1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout t=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
